spi_mem_ctrl: RTL and testbench

Command controller between the SPI slave's parallel port and a single-port synchronous memory. It decodes each 10-bit word from the slave (`rx_data`/`rx_valid`), sequences memory writes and reads, and returns read data to the slave on `tx_data`/`tx_valid` for shifting out on MISO. Together with the SPI slave and the memory, it forms the SPI-to-RAM wrapper.

---
 rtl/spi_mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_spi_mem_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_ctrl.sv
// Command controller between an SPI slave's parallel word port and a single-port sync RAM.
// Decodes opcode/payload words on rx_valid rising edges and returns read data on tx_data.
module spi_mem_ctrl #(
  parameter int unsigned TX_HOLD = 10,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              cmd_err
);

  typedef enum logic [1:0] {StIdle, StRdWait, StRdCapt, StTxHold} state_e;

  localparam logic [7:0] HoldInit = 8'(TX_HOLD - 1);

  state_e            state_q, state_d;
  logic              rx_valid_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_armed_q, rd_armed_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;

  logic [7:0]        tx_data_d;
  logic              tx_valid_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;
  logic              mem_we_d, mem_re_d, cmd_err_d;

  logic              cmd_edge;
  logic              accept;
  logic [1:0]        opcode;
  logic [ADDR_W-1:0] payload;

  assign cmd_edge = rx_valid & ~rx_valid_q;
  assign opcode   = rx_data[9:8];
  assign payload  = rx_data[ADDR_W-1:0];

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    rd_armed_d  = rd_armed_q;
    hold_cnt_d  = hold_cnt_q;
    tx_data_d   = tx_data;
    tx_valid_d  = tx_valid;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    cmd_err_d   = 1'b0;
    accept      = 1'b0;

    case (state_q)
      StIdle: accept = cmd_edge;
      StRdWait: begin
        state_d   = StRdCapt;
        cmd_err_d = cmd_edge;
      end
      StRdCapt: begin
        tx_data_d  = mem_rdata;
        tx_valid_d = 1'b1;
        hold_cnt_d = HoldInit;
        state_d    = StTxHold;
        cmd_err_d  = cmd_edge;
      end
      StTxHold: begin
        // A new command cuts the response short and is handled as if idle.
        if (cmd_edge) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
          accept     = 1'b1;
        end else if (hold_cnt_q == 8'd0) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      case (opcode)
        2'b00: wr_addr_d = payload;
        2'b01: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr_q;
          mem_wdata_d = payload;
          wr_addr_d   = wr_addr_q + 1'b1;
        end
        2'b10: begin
          rd_addr_d  = payload;
          rd_armed_d = 1'b1;
        end
        default: begin
          if (rd_armed_q) begin
            state_d    = StRdWait;
            mem_re_d   = 1'b1;
            mem_addr_d = rd_addr_q;
            rd_armed_d = 1'b0;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rx_valid_q <= 1'b1;  // a level already high at release must not fire
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rd_armed_q <= 1'b0;
      hold_cnt_q <= 8'd0;
      tx_data    <= 8'd0;
      tx_valid   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'd0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= rx_valid;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      rd_armed_q <= rd_armed_d;
      hold_cnt_q <= hold_cnt_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      mem_we     <= mem_we_d;
      mem_re     <= mem_re_d;
      cmd_err    <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: directed scenarios plus a random command stream checked
// against a cycle-timeline model of the command protocol.
module tb_spi_mem_ctrl;
  localparam int H    = 10;
  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] rx_data = 10'd0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we, mem_re, cmd_err;
  logic [7:0] mem_rdata;

  spi_mem_ctrl #(.TX_HOLD(H), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple synchronous RAM; reloads a seed image while reset is high.
  logic [7:0] seed_mem [256];
  logic [7:0] tb_mem   [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= seed_mem[i];
      mem_rdata <= 8'd0;
    end else begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= tb_mem[mem_addr];
    end
  end

  logic       r_we [MAXC], r_re [MAXC], r_err [MAXC], r_txv [MAXC];
  logic [7:0] r_addr [MAXC], r_wdata [MAXC], r_txd [MAXC];
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      r_we[cyc]    <= mem_we;
      r_re[cyc]    <= mem_re;
      r_err[cyc]   <= cmd_err;
      r_txv[cyc]   <= tx_valid;
      r_addr[cyc]  <= mem_addr;
      r_wdata[cyc] <= mem_wdata;
      r_txd[cyc]   <= tx_data;
    end
  end

  // Expected timeline, filled in when each command edge is issued.
  bit         e_we [MAXC], e_re [MAXC], e_err [MAXC], e_txv [MAXC];
  logic [7:0] e_addr [MAXC], e_wdata [MAXC], e_txd [MAXC];
  logic [7:0] m_mem [256];
  logic [7:0] m_wr, m_rd;
  bit         m_armed;
  int         m_acc, m_win_end;

  int tests = 0;
  int fails = 0;

  task automatic model_reset(input int c);
    for (int i = c; i < MAXC; i++) begin
      e_we[i] = 0; e_re[i] = 0; e_err[i] = 0; e_txv[i] = 0;
      e_addr[i] = 8'd0; e_wdata[i] = 8'd0; e_txd[i] = 8'd0;
    end
    for (int i = 0; i < 256; i++) m_mem[i] = seed_mem[i];
    m_wr = 8'd0; m_rd = 8'd0; m_armed = 0; m_acc = -100; m_win_end = -100;
  endtask

  task automatic model_edge(input int n, input logic [9:0] w);
    logic [7:0] p;
    p = w[7:0];
    // The two cycles after an accepted read cannot take a command.
    if (n == m_acc + 1 || n == m_acc + 2) begin
      e_err[n+1] = 1;
      return;
    end
    if (n >= m_acc + 3 && n <= m_win_end) begin
      for (int c = n + 1; c <= m_win_end; c++) e_txv[c] = 0;
      m_win_end = n;
    end
    case (w[9:8])
      2'b00: m_wr = p;
      2'b01: begin
        e_we[n+1] = 1; e_addr[n+1] = m_wr; e_wdata[n+1] = p;
        m_mem[m_wr] = p;
        m_wr = m_wr + 8'd1;
      end
      2'b10: begin m_rd = p; m_armed = 1; end
      default: begin
        if (m_armed) begin
          e_re[n+1] = 1; e_addr[n+1] = m_rd; m_armed = 0;
          m_acc = n; m_win_end = n + 2 + H;
          for (int c = n + 3; c <= m_win_end; c++) e_txv[c] = 1;
          for (int c = n + 3; c < MAXC; c++) e_txd[c] = m_mem[m_rd];
        end else begin
          e_err[n+1] = 1;
        end
      end
    endcase
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] w, input int hold, input int gap, output int n);
    rx_data = w; rx_valid = 1'b1;
    n = cyc;
    model_edge(cyc, w);
    wait_cycles(hold);
    rx_valid = 1'b0;
    wait_cycles(gap);
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0;
    wait_cycles(2);
    rst = 1'b0;
    model_reset(cyc);
    wait_cycles(1);
  endtask

  task automatic test_reset();
    wait_cycles(2);
    @(negedge clk);
    tests += 7;
    if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    if (mem_addr !== 8'h00) begin fails++; $display("FAIL reset_mem_addr got %h want 00", mem_addr); end
    if (mem_wdata !== 8'h00) begin fails++; $display("FAIL reset_mem_wdata got %h want 00", mem_wdata); end
    if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    if (mem_re !== 1'b0) begin fails++; $display("FAIL reset_mem_re got %b want 0", mem_re); end
    if (cmd_err !== 1'b0) begin fails++; $display("FAIL reset_cmd_err got %b want 0", cmd_err); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset(cyc);
    wait_cycles(1);
  endtask

  task automatic test_write_read();
    int n, nw, nr, cnt;
    send(10'h0A5, 1, 1, n);
    send(10'h13C, 1, 1, nw);
    send(10'h2A5, 1, 1, n);
    send(10'h300, 1, 1, nr);
    wait_cycles(14);
    cnt = 0;
    for (int c = nr; c < nr + 16; c++) cnt += int'(r_txv[c]);
    tests += 9;
    if (r_we[nw+1] !== 1'b1) begin fails++; $display("FAIL wr_we got %b want 1", r_we[nw+1]); end
    if (r_we[nw+2] !== 1'b0) begin fails++; $display("FAIL wr_we_once got %b want 0", r_we[nw+2]); end
    if (r_addr[nw+1] !== 8'hA5) begin fails++; $display("FAIL wr_addr got %h want a5", r_addr[nw+1]); end
    if (r_wdata[nw+1] !== 8'h3C) begin fails++; $display("FAIL wr_data got %h want 3c", r_wdata[nw+1]); end
    if (r_re[nr+1] !== 1'b1) begin fails++; $display("FAIL rd_re got %b want 1", r_re[nr+1]); end
    if (r_txv[nr+2] !== 1'b0) begin fails++; $display("FAIL rd_txv_early got %b want 0", r_txv[nr+2]); end
    if (r_txv[nr+3] !== 1'b1) begin fails++; $display("FAIL rd_txv_start got %b want 1", r_txv[nr+3]); end
    if (cnt != H) begin fails++; $display("FAIL rd_txv_len got %0d want %0d", cnt, H); end
    if (r_txd[nr+3] !== 8'h3C || r_txd[nr+15] !== 8'h3C) begin
      fails++; $display("FAIL rd_tx_data got %h/%h want 3c", r_txd[nr+3], r_txd[nr+15]);
    end
  endtask

  task automatic test_wrap();
    int n, n1, n2;
    send(10'h0FF, 1, 1, n);
    send(10'h111, 1, 1, n1);
    send(10'h122, 1, 1, n2);
    wait_cycles(1);
    tests += 3;
    if (r_we[n1+1] !== 1'b1 || r_addr[n1+1] !== 8'hFF) begin
      fails++; $display("FAIL wrap_first we=%b addr=%h want 1/ff", r_we[n1+1], r_addr[n1+1]);
    end
    if (r_we[n2+1] !== 1'b1 || r_addr[n2+1] !== 8'h00) begin
      fails++; $display("FAIL wrap_second we=%b addr=%h want 1/00", r_we[n2+1], r_addr[n2+1]);
    end
    if (r_wdata[n2+1] !== 8'h22) begin fails++; $display("FAIL wrap_data got %h want 22", r_wdata[n2+1]); end
  endtask

  task automatic test_unarmed();
    int n, nr, n2, cnt;
    do_reset();
    send(10'h300, 1, 1, n);
    wait_cycles(6);
    cnt = 0;
    for (int c = n; c < n + 8; c++) cnt += int'(r_re[c]) + int'(r_txv[c]);
    tests += 3;
    if (r_err[n+1] !== 1'b1) begin fails++; $display("FAIL unarmed_err got %b want 1", r_err[n+1]); end
    if (r_err[n+2] !== 1'b0) begin fails++; $display("FAIL unarmed_err_len got %b want 0", r_err[n+2]); end
    if (cnt != 0) begin fails++; $display("FAIL unarmed_access got %0d strobes want 0", cnt); end
    send(10'h210, 1, 1, n);
    send(10'h300, 1, 1, nr);
    wait_cycles(14);
    send(10'h300, 1, 1, n2);
    wait_cycles(6);
    cnt = 0;
    for (int c = n2; c < n2 + 8; c++) cnt += int'(r_re[c]) + int'(r_txv[c]);
    tests += 2;
    if (r_err[n2+1] !== 1'b1) begin fails++; $display("FAIL reread_err got %b want 1", r_err[n2+1]); end
    if (cnt != 0) begin fails++; $display("FAIL reread_access got %0d strobes want 0", cnt); end
  endtask

  task automatic test_held();
    int n, cnt;
    send(10'h155, 20, 2, n);
    cnt = 0;
    for (int c = n; c < n + 22; c++) cnt += int'(r_we[c]);
    tests++;
    if (cnt != 1) begin fails++; $display("FAIL held_we_count got %0d want 1", cnt); end
  endtask

  task automatic test_abort();
    int n, nr, ne;
    send(10'h240, 1, 1, n);
    send(10'h300, 1, 1, nr);
    wait_cycles(3);
    send(10'h177, 1, 1, ne);
    wait_cycles(2);
    tests += 4;
    if (r_txv[ne] !== 1'b1) begin fails++; $display("FAIL abort_txv_before got %b want 1", r_txv[ne]); end
    if (r_txv[ne+1] !== 1'b0) begin fails++; $display("FAIL abort_txv_drop got %b want 0", r_txv[ne+1]); end
    if (r_we[ne+1] !== 1'b1 || r_wdata[ne+1] !== 8'h77) begin
      fails++; $display("FAIL abort_write we=%b data=%h want 1/77", r_we[ne+1], r_wdata[ne+1]);
    end
    if (r_txd[ne] !== e_txd[ne]) begin fails++; $display("FAIL abort_tx_data got %h want %h", r_txd[ne], e_txd[ne]); end
  endtask

  task automatic test_drop();
    int n, nr, nd, cnt;
    send(10'h250, 1, 1, n);
    send(10'h300, 1, 1, nr);
    send(10'h199, 1, 1, nd);
    wait_cycles(12);
    cnt = 0;
    for (int c = nr; c < nr + 16; c++) cnt += int'(r_txv[c]);
    tests += 4;
    if (r_err[nd+1] !== 1'b1) begin fails++; $display("FAIL drop_err got %b want 1", r_err[nd+1]); end
    if (r_we[nd+1] !== 1'b0) begin fails++; $display("FAIL drop_we got %b want 0", r_we[nd+1]); end
    if (cnt != H) begin fails++; $display("FAIL drop_txv_len got %0d want %0d", cnt, H); end
    if (r_txd[nr+3] !== e_txd[nr+3]) begin
      fails++; $display("FAIL drop_tx_data got %h want %h", r_txd[nr+3], e_txd[nr+3]);
    end
  endtask

  task automatic test_reset_mid_read();
    int n, nr, c0, cnt;
    send(10'h220, 1, 1, n);
    send(10'h300, 1, 1, nr);
    rx_data = 10'h300; rx_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re, cmd_err} !== 28'd0) begin
      fails++;
      $display("FAIL midrst_outputs txd=%h txv=%b addr=%h wd=%h we=%b re=%b err=%b want all 0",
               tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re, cmd_err);
    end
    wait_cycles(2);
    rst = 1'b0;
    model_reset(cyc);
    c0 = cyc;
    wait_cycles(6);
    cnt = 0;
    for (int c = c0; c < c0 + 6; c++) cnt += int'(r_we[c]) + int'(r_re[c]) + int'(r_err[c]);
    tests++;
    if (cnt != 0) begin fails++; $display("FAIL midrst_held_fires got %0d pulses want 0", cnt); end
    rx_valid = 1'b0;
    wait_cycles(1);
    send(10'h300, 1, 4, n);
    tests += 2;
    if (r_err[n+1] !== 1'b1) begin fails++; $display("FAIL midrst_disarm_err got %b want 1", r_err[n+1]); end
    if (r_re[n+1] !== 1'b0) begin fails++; $display("FAIL midrst_disarm_re got %b want 0", r_re[n+1]); end
  endtask

  task automatic test_random();
    int n, start, stop;
    logic [9:0] w;
    do_reset();
    start = cyc;
    for (int i = 0; i < 90; i++) begin
      w = 10'($urandom_range(0, 1023));
      send(w, $urandom_range(1, 3), $urandom_range(1, 14), n);
    end
    wait_cycles(16);
    stop = cyc;
    for (int c = start; c < stop; c++) begin
      tests++;
      if (r_we[c] !== e_we[c] || r_re[c] !== e_re[c] || r_err[c] !== e_err[c] ||
          r_txv[c] !== e_txv[c]) begin
        fails++;
        $display("FAIL rand_strobes cyc %0d we/re/err/txv got %b%b%b%b want %b%b%b%b", c,
                 r_we[c], r_re[c], r_err[c], r_txv[c], e_we[c], e_re[c], e_err[c], e_txv[c]);
      end
      if ((e_we[c] || e_re[c]) && r_addr[c] !== e_addr[c]) begin
        tests++; fails++;
        $display("FAIL rand_addr cyc %0d got %h want %h", c, r_addr[c], e_addr[c]);
      end
      if (e_we[c] && r_wdata[c] !== e_wdata[c]) begin
        tests++; fails++;
        $display("FAIL rand_wdata cyc %0d got %h want %h", c, r_wdata[c], e_wdata[c]);
      end
      if (e_txv[c] && r_txd[c] !== e_txd[c]) begin
        tests++; fails++;
        $display("FAIL rand_tx_data cyc %0d got %h want %h", c, r_txd[c], e_txd[c]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) seed_mem[i] = 8'($urandom_range(1, 255));
    test_reset();
    test_write_read();
    test_wrap();
    test_unarmed();
    test_held();
    test_abort();
    test_drop();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
